// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default width/step for the even sequence controller
// Contents: state_t (IDLE, LOAD, RUN, DONE), W_DEF (data width), STEP_DEF (increment per term)
package seq_pkg;
    localparam int W_DEF    = 8;
    localparam int STEP_DEF = 2;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;
endpackage

// File: rtl/seq_counter.sv
// seq_counter: W-bit term register with load, +STEP increment and carry out
// Ports: clk, reset_ (async active-low), load/d (load d), en (add STEP), q (current term), carry (q+STEP overflows W bits)
module seq_counter
    import seq_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int STEP = STEP_DEF
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         carry
);
    logic [W:0] sum;
    assign sum   = {1'b0, q} + (W+1)'(STEP);
    assign carry = sum[W];
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)
            q <= '0;
        else if (load)
            q <= d;
        else if (en)
            q <= sum[W-1:0];
    end
endmodule

// File: rtl/even_seq_ctrl.sv
// even_seq_ctrl: steps seed, seed+STEP, ... and hands out one term per valid/ready transfer
// Ports: clk, reset_ (async active-low); command side start/abort/seed/count/wrap_en;
//        consumer side out_ready/out_valid/out_data; status busy (not IDLE), done (one-cycle completion pulse)
module even_seq_ctrl
    import seq_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int STEP = STEP_DEF
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] seed,
    input  logic [W-1:0] count,
    input  logic         wrap_en,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         done
);
    state_t       state, state_n;
    logic [W-1:0] rem;
    logic         wrap_q, xfer, last, load, inc, carry;
    assign load = state == IDLE && start;
    seq_counter #(.W(W), .STEP(STEP)) u_cnt (
        .clk   (clk),
        .reset_(reset_),
        .load  (load),
        .en    (inc),
        .d     ({seed[W-1:1], 1'b0}),
        .q     (out_data),
        .carry (carry)
    );
    // last: the term being transferred ends the sequence, either because it is
    // the final requested term or because its successor would overflow without wrap
    always_comb begin
        xfer = out_valid && out_ready;
        last = rem == W'(1) || (carry && !wrap_q);
        inc  = state == RUN && !abort && xfer && !last;
        case (state)
            IDLE:    state_n = start ? LOAD : IDLE;
            LOAD:    state_n = (abort || rem == '0) ? DONE : RUN;
            RUN:     state_n = (abort || (xfer && last)) ? DONE : RUN;
            default: state_n = IDLE;
        endcase
    end
    // out_valid only rises from the second RUN cycle onward, i.e. two edges
    // after start; it drops on the same edge that leaves RUN
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= IDLE;
            rem       <= '0;
            wrap_q    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            out_valid <= state == RUN && state_n == RUN;
            busy      <= state_n != IDLE;
            done      <= state_n == DONE;
            if (load) begin
                rem    <= count;
                wrap_q <= wrap_en;
            end else if (inc) begin
                rem <= rem - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_even_seq_ctrl.sv
// tb_even_seq_ctrl: table-driven and hand-written sequences with a term scoreboard
module tb_even_seq_ctrl;
    logic       clk = 1'b0;
    logic       reset_, start, abort, wrap_en, out_ready;
    logic [7:0] seed, count, out_data;
    logic       out_valid, busy, done;
    int         checks = 0, failures = 0, got = 0, dones = 0;
    logic [7:0] q[$];
    logic       stall_pend = 1'b0;
    logic [7:0] stall_data = '0;

    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
        logic       w;
        int         mode;
        int         exp_n;
    } vec_t;
    vec_t tbl[9];

    even_seq_ctrl #(.W(8), .STEP(2)) dut (
        .clk(clk), .reset_(reset_), .start(start), .abort(abort),
        .seed(seed), .count(count), .wrap_en(wrap_en), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Scoreboard: a term is consumed at the next edge when valid&ready and no abort
    always @(negedge clk) begin
        if (!reset_) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), int'(stall_data));
            end
            stall_pend = 1'b0;
            if (done) dones++;
            if (out_valid && !abort) begin
                if (out_ready) begin
                    if (q.size() == 0) chk("extra_term", int'(out_data), -1);
                    else chk("term", int'(out_data), int'(q.pop_front()));
                    got++;
                end else begin
                    stall_pend = 1'b1;
                    stall_data = out_data;
                end
            end
        end
    end

    task automatic push_model(input logic [7:0] s, input logic [7:0] c, input logic w);
        logic [8:0] v;
        v = {1'b0, s[7:1], 1'b0};
        for (int k = 0; k < int'(c); k++) begin
            q.push_back(v[7:0]);
            v = v + 9'd2;
            if (v[8]) begin
                if (!w) break;
                v[8] = 1'b0;
            end
        end
    endtask

    task automatic run(input vec_t t);
        int k;
        got = 0;
        dones = 0;
        push_model(t.s, t.c, t.w);
        @(posedge clk); #1;
        seed = t.s; count = t.c; wrap_en = t.w; start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            out_ready = (t.mode == 0) ? 1'b1 : ((k % 3) == 0);
            @(posedge clk); #1;
            k++;
        end
        chk("timeout", int'(k < 200), 1);
        @(posedge clk); #1;
        chk("terms", got, t.exp_n);
        chk("sb_empty", q.size(), 0);
        chk("done_pulses", dones, 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_valid", int'(out_valid), 0);
        q.delete();
    endtask

    initial begin
        tbl[0] = '{8'd4,   8'd3, 1'b1, 0, 3};
        tbl[1] = '{8'd7,   8'd2, 1'b1, 0, 2};
        tbl[2] = '{8'd10,  8'd5, 1'b1, 1, 5};
        tbl[3] = '{8'd252, 8'd4, 1'b1, 0, 4};
        tbl[4] = '{8'd252, 8'd4, 1'b0, 0, 2};
        tbl[5] = '{8'd0,   8'd0, 1'b1, 0, 0};
        tbl[6] = '{8'd250, 8'd3, 1'b0, 1, 3};
        tbl[7] = '{8'd254, 8'd2, 1'b0, 0, 1};
        tbl[8] = '{8'd252, 8'd4, 1'b1, 1, 4};
        reset_ = 1'b0; start = 1'b0; abort = 1'b0; wrap_en = 1'b0;
        out_ready = 1'b0; seed = '0; count = '0;
        #12;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk); reset_ = 1'b1;

        // latency: seed 4, count 3, ready high
        got = 0; dones = 0;
        q.push_back(8'd4); q.push_back(8'd6); q.push_back(8'd8);
        @(posedge clk); #1;
        seed = 8'd4; count = 8'd3; wrap_en = 1'b1; out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("lat_n_valid", int'(out_valid), 0);
        chk("lat_n_busy", int'(busy), 1);
        @(posedge clk); #1;
        chk("lat_n1_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_n2_valid", int'(out_valid), 1);
        chk("lat_n2_data", int'(out_data), 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat_n4_data", int'(out_data), 8);
        @(posedge clk); #1;
        chk("lat_done", int'(done), 1);
        chk("lat_done_valid", int'(out_valid), 0);
        chk("lat_done_busy", int'(busy), 1);
        @(posedge clk); #1;
        chk("lat_post_done", int'(done), 0);
        chk("lat_post_busy", int'(busy), 0);
        chk("lat_hold_data", int'(out_data), 8);
        chk("lat_terms", got, 3);

        // count 0: busy through LOAD and DONE only
        @(posedge clk); #1;
        count = 8'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("c0_busy_load", int'(busy), 1);
        chk("c0_nodone", int'(done), 0);
        @(posedge clk); #1;
        chk("c0_done", int'(done), 1);
        chk("c0_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("c0_idle", int'(busy), 0);

        for (int i = 0; i < 9; i++) run(tbl[i]);

        // abort after the second term; start+abort together in IDLE starts
        got = 0; dones = 0;
        q.push_back(8'd20); q.push_back(8'd22);
        @(posedge clk); #1;
        seed = 8'd20; count = 8'd6; wrap_en = 1'b1; out_ready = 1'b1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        chk("start_wins", int'(busy), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ab_data0", int'(out_data), 20);
        seed = 8'd100; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("ab_valid", int'(out_valid), 0);
        chk("ab_done", int'(done), 1);
        @(posedge clk); #1;
        chk("ab_idle", int'(busy), 0);
        chk("ab_terms", got, 2);
        chk("ab_sb_empty", q.size(), 0);
        chk("ab_dones", dones, 1);
        q.delete();

        // async reset mid-RUN
        got = 0;
        q.push_back(8'd40);
        @(posedge clk); #1;
        seed = 8'd40; count = 8'd10; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 reset_ = 1'b0;
        #1;
        chk("ar_valid", int'(out_valid), 0);
        chk("ar_data", int'(out_data), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_done", int'(done), 0);
        @(negedge clk); reset_ = 1'b1;
        @(posedge clk); #1;
        chk("ar_stay_idle", int'(busy), 0);
        chk("ar_terms", got, 1);
        chk("ar_sb_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
